// File: rtl/mcu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_sequencer
//  Purpose  : LOAD / CONV / OUT control sequencer for the 2D-convolution MCU;
//             drives mux-array state lines plus column-memory addresses/strobes.
//  Option   : define MCU_SEQ_ERRFLAG_EN to add the sticky o_err port.
//  Revision : 1.0 - initial release
// ============================================================================
module mcu_sequencer #(
    parameter int N         = 4,
    parameter int BITS_ADDR = 10,
    parameter int CONV_LAT  = 3,
    localparam int SUB_W    = (N > 2) ? $clog2(N / 2) : 1,
    localparam int SEL_W    = $clog2(N + 1)
) (
    input  logic                 i_CLK,
    input  logic                 i_reset,
    input  logic [BITS_ADDR-1:0] i_imgLength,
    input  logic                 i_valid,
    input  logic                 i_run,
    input  logic                 i_rdReq,
    output logic [1:0]           o_state,
    output logic [SUB_W-1:0]     o_substate,
    output logic [SEL_W-1:0]     o_memSelect,
    output logic [BITS_ADDR-1:0] o_addrWr,
    output logic [BITS_ADDR-1:0] o_addrRd,
    output logic                 o_we,
    output logic                 o_re,
    output logic                 o_loadDone,
    output logic                 o_convDone,
    output logic                 o_outDone
`ifdef MCU_SEQ_ERRFLAG_EN
    ,
    output logic                 o_err
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CONV = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0]     c_sel_load_last = SEL_W'(N + 1);
    localparam logic [SEL_W-1:0]     c_sel_conv      = SEL_W'(N);
    localparam logic [SEL_W-1:0]     c_sel_out_last  = SEL_W'(N - 1);
    localparam logic [SUB_W-1:0]     c_sub_last      = SUB_W'(N / 2 - 1);
    localparam logic [BITS_ADDR-1:0] c_min_h         = BITS_ADDR'(3);

    state_t               r_state;
    logic [BITS_ADDR-1:0] r_h;
    logic                 r_started;
    logic                 r_loaded;
    logic                 r_out_started;
    logic [CONV_LAT-1:0]  r_re_pipe;
    logic [BITS_ADDR-1:0] r_addr_pipe [CONV_LAT];

    logic [BITS_ADDR-1:0] w_h_last;
    logic                 w_load_fin;
    logic                 w_conv_fin;
    logic                 w_out_fin;
    logic                 w_run_ok;
    logic                 w_cre;
    logic [BITS_ADDR-1:0] w_caddr;

    assign o_state = r_state;

    // Phase completion is detected from the registered strobes of the final
    // access, which places each done pulse one cycle after that access.
    always_comb begin
        w_h_last   = r_h - 1'b1;
        w_load_fin = (r_state == ST_LOAD) && o_we && (o_memSelect == c_sel_load_last)
                     && (o_addrWr == w_h_last);
        w_conv_fin = (r_state == ST_CONV) && o_we && (o_addrWr == w_h_last);
        w_out_fin  = (r_state == ST_OUT) && o_re && (o_memSelect == c_sel_out_last)
                     && (o_addrRd == w_h_last);
        w_run_ok   = (r_state == ST_LOAD) && i_run && r_loaded;
        w_cre      = w_run_ok || ((r_state == ST_CONV) && o_re && (o_addrRd != w_h_last));
        w_caddr    = w_run_ok ? '0 : o_addrRd + 1'b1;
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            r_state       <= ST_LOAD;
            r_h           <= '0;
            r_started     <= 1'b0;
            r_loaded      <= 1'b0;
            r_out_started <= 1'b0;
            r_re_pipe     <= '0;
            for (int i = 0; i < CONV_LAT; i++) r_addr_pipe[i] <= '0;
            o_substate    <= '0;
            o_memSelect   <= '0;
            o_addrWr      <= '0;
            o_addrRd      <= '0;
            o_we          <= 1'b0;
            o_re          <= 1'b0;
            o_loadDone    <= 1'b0;
            o_convDone    <= 1'b0;
            o_outDone     <= 1'b0;
        end else begin
            o_we         <= 1'b0;
            o_re         <= 1'b0;
            o_loadDone   <= 1'b0;
            o_convDone   <= 1'b0;
            o_outDone    <= 1'b0;
            // Convolver latency model: each CONV read re-emerges as a write-back.
            r_re_pipe[0]   <= w_cre;
            r_addr_pipe[0] <= w_caddr;
            for (int i = 1; i < CONV_LAT; i++) begin
                r_re_pipe[i]   <= r_re_pipe[i-1];
                r_addr_pipe[i] <= r_addr_pipe[i-1];
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_load_fin) begin
                        o_loadDone  <= 1'b1;
                        o_memSelect <= '0;
                        o_addrWr    <= '0;
                        r_loaded    <= 1'b1;
                    end else if (w_run_ok) begin
                        r_state     <= ST_CONV;
                        o_re        <= 1'b1;
                        o_addrRd    <= '0;
                        o_memSelect <= c_sel_conv;
                    end else if (i_valid && !r_loaded) begin
                        if (!r_started) begin
                            if (i_imgLength >= c_min_h) begin
                                r_h         <= i_imgLength;
                                r_started   <= 1'b1;
                                o_we        <= 1'b1;
                                o_addrWr    <= '0;
                                o_memSelect <= '0;
                            end
                        end else begin
                            o_we <= 1'b1;
                            if (o_addrWr == w_h_last) begin
                                o_addrWr    <= '0;
                                o_memSelect <= o_memSelect + 1'b1;
                            end else begin
                                o_addrWr <= o_addrWr + 1'b1;
                            end
                        end
                    end
                end

                ST_CONV: begin
                    o_re <= w_cre;
                    if (w_cre) o_addrRd <= w_caddr;
                    if (w_conv_fin) begin
                        o_convDone  <= 1'b1;
                        r_state     <= ST_OUT;
                        o_substate  <= (o_substate == c_sub_last) ? '0 : o_substate + 1'b1;
                        o_memSelect <= '0;
                        o_addrWr    <= '0;
                        o_addrRd    <= '0;
                    end else if (r_re_pipe[CONV_LAT-1]) begin
                        o_we     <= 1'b1;
                        o_addrWr <= r_addr_pipe[CONV_LAT-1];
                    end
                end

                ST_OUT: begin
                    if (w_out_fin) begin
                        o_outDone     <= 1'b1;
                        r_state       <= ST_LOAD;
                        o_memSelect   <= '0;
                        o_addrWr      <= '0;
                        o_addrRd      <= '0;
                        r_started     <= 1'b0;
                        r_loaded      <= 1'b0;
                        r_out_started <= 1'b0;
                    end else if (i_rdReq) begin
                        o_re <= 1'b1;
                        if (!r_out_started) begin
                            r_out_started <= 1'b1;
                        end else if (o_addrRd == w_h_last) begin
                            o_addrRd    <= '0;
                            o_memSelect <= o_memSelect + 1'b1;
                        end else begin
                            o_addrRd <= o_addrRd + 1'b1;
                        end
                    end
                end

                default: r_state <= ST_LOAD;
            endcase
        end
    end

`ifdef MCU_SEQ_ERRFLAG_EN
    logic w_ignored;

    always_comb begin
        w_ignored = (i_valid && ((r_state != ST_LOAD) || r_loaded || w_load_fin
                                 || (!r_started && (i_imgLength < c_min_h))))
                  || (i_run && !w_run_ok)
                  || (i_rdReq && ((r_state != ST_OUT) || w_out_fin));
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            o_err <= 1'b0;
        end else if (w_ignored) begin
            o_err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcu_sequencer.sv
`default_nettype none
// Directed-vector bench for mcu_sequencer (N=4, H=4, CONV_LAT=3).
module tb_mcu_sequencer;

    logic       clk = 1'b0;
    logic       i_reset, i_valid, i_run, i_rdReq;
    logic [9:0] i_imgLength;
    logic [1:0] o_state;
    logic [0:0] o_substate;
    logic [2:0] o_memSelect;
    logic [9:0] o_addrWr, o_addrRd;
    logic       o_we, o_re, o_loadDone, o_convDone, o_outDone;
`ifdef MCU_SEQ_ERRFLAG_EN
    logic       o_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcu_sequencer #(.N(4), .BITS_ADDR(10), .CONV_LAT(3)) dut (
        .i_CLK       (clk),
        .i_reset     (i_reset),
        .i_imgLength (i_imgLength),
        .i_valid     (i_valid),
        .i_run       (i_run),
        .i_rdReq     (i_rdReq),
        .o_state     (o_state),
        .o_substate  (o_substate),
        .o_memSelect (o_memSelect),
        .o_addrWr    (o_addrWr),
        .o_addrRd    (o_addrRd),
        .o_we        (o_we),
        .o_re        (o_re),
        .o_loadDone  (o_loadDone),
        .o_convDone  (o_convDone),
        .o_outDone   (o_outDone)
`ifdef MCU_SEQ_ERRFLAG_EN
        ,
        .o_err       (o_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_run = 1'b0; i_rdReq = 1'b0; i_imgLength = 10'd4;
        tick(); tick();
        checks++;
        if ({o_state, o_substate, o_memSelect, o_addrWr, o_addrRd} !== 29'd0) begin
            errors++;
            $display("FAIL reset_regs: got state=%0d sub=%0d sel=%0d wr=%0d rd=%0d expected all 0",
                     o_state, o_substate, o_memSelect, o_addrWr, o_addrRd);
        end
        checks++;
        if ({o_we, o_re, o_loadDone, o_convDone, o_outDone} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {o_we, o_re, o_loadDone, o_convDone, o_outDone});
        end
`ifdef MCU_SEQ_ERRFLAG_EN
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
`endif
        i_reset = 1'b0;
    endtask

    task automatic test_load(input string tag);
        logic [2:0] exp_sel;
        logic [9:0] exp_addr;
        for (int k = 0; k < 24; k++) begin
            i_imgLength = 10'd4; i_valid = 1'b1;
            tick();
            exp_sel  = 3'(k / 4);
            exp_addr = 10'(k % 4);
            checks++;
            if (o_we !== 1'b1 || o_memSelect !== exp_sel || o_addrWr !== exp_addr || o_loadDone !== 1'b0) begin
                errors++;
                $display("FAIL %s load_write k=%0d: got we=%b sel=%0d addr=%0d done=%b expected we=1 sel=%0d addr=%0d done=0",
                         tag, k, o_we, o_memSelect, o_addrWr, o_loadDone, exp_sel, exp_addr);
            end
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (o_loadDone !== 1'b1 || o_we !== 1'b0 || o_memSelect !== 3'd0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL %s load_done: got done=%b we=%b sel=%0d state=%0d expected 1 0 0 0",
                     tag, o_loadDone, o_we, o_memSelect, o_state);
        end
        tick();
        checks++;
        if (o_loadDone !== 1'b0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL %s load_done_width: got done=%b state=%0d expected 0 0", tag, o_loadDone, o_state);
        end
    endtask

    // Read sweep c=0..3, write-backs c=3..6, convDone at c=7.
    task automatic test_conv(input logic [0:0] exp_sub, input logic noise);
        logic exp_re, exp_we, exp_done;
        logic [9:0] exp_rd, exp_wr;
        for (int c = 0; c < 8; c++) begin
            i_run   = (c == 0);
            i_valid = noise && (c > 0) && (c < 6);
            i_rdReq = noise && (c > 0);
            tick();
            exp_re   = (c < 4);
            exp_we   = (c >= 3) && (c <= 6);
            exp_done = (c == 7);
            exp_rd   = 10'(c);
            exp_wr   = 10'(c - 3);
            checks++;
            if (o_re !== exp_re || (exp_re && o_addrRd !== exp_rd)) begin
                errors++;
                $display("FAIL conv_read c=%0d: got re=%b addr=%0d expected re=%b addr=%0d",
                         c, o_re, o_addrRd, exp_re, exp_rd);
            end
            checks++;
            if (o_we !== exp_we || (exp_we && (o_addrWr !== exp_wr || o_memSelect !== 3'd4))) begin
                errors++;
                $display("FAIL conv_write c=%0d: got we=%b addr=%0d sel=%0d expected we=%b addr=%0d sel=4",
                         c, o_we, o_addrWr, o_memSelect, exp_we, exp_wr);
            end
            checks++;
            if (o_convDone !== exp_done || o_state !== (exp_done ? 2'd2 : 2'd1)) begin
                errors++;
                $display("FAIL conv_phase c=%0d: got done=%b state=%0d expected done=%b state=%0d",
                         c, o_convDone, o_state, exp_done, exp_done ? 2 : 1);
            end
        end
        i_valid = 1'b0; i_rdReq = 1'b0;
        checks++;
        if (o_substate !== exp_sub) begin
            errors++;
            $display("FAIL conv_substate: got %0d expected %0d", o_substate, exp_sub);
        end
    endtask

    task automatic test_out();
        logic [2:0] exp_sel;
        logic [9:0] exp_addr;
        for (int k = 0; k < 16; k++) begin
            i_rdReq = 1'b1;
            tick();
            exp_sel  = 3'(k / 4);
            exp_addr = 10'(k % 4);
            checks++;
            if (o_re !== 1'b1 || o_we !== 1'b0 || o_memSelect !== exp_sel || o_addrRd !== exp_addr
                || o_state !== 2'd2 || o_convDone !== 1'b0) begin
                errors++;
                $display("FAIL out_read k=%0d: got re=%b we=%b sel=%0d addr=%0d state=%0d cdone=%b expected re=1 we=0 sel=%0d addr=%0d state=2 cdone=0",
                         k, o_re, o_we, o_memSelect, o_addrRd, o_state, o_convDone, exp_sel, exp_addr);
            end
        end
        i_rdReq = 1'b0;
        tick();
        checks++;
        if (o_outDone !== 1'b1 || o_state !== 2'd0 || o_memSelect !== 3'd0 || o_addrRd !== 10'd0 || o_re !== 1'b0) begin
            errors++;
            $display("FAIL out_done: got done=%b state=%0d sel=%0d rd=%0d re=%b expected 1 0 0 0 0",
                     o_outDone, o_state, o_memSelect, o_addrRd, o_re);
        end
        tick();
        checks++;
        if (o_outDone !== 1'b0) begin
            errors++;
            $display("FAIL out_done_width: got %b expected 0", o_outDone);
        end
    endtask

    task automatic test_ignored();
        i_rdReq = 1'b1;
        tick();
        i_rdReq = 1'b0; i_run = 1'b1;
        checks++;
        if (o_we !== 1'b0 || o_re !== 1'b0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL ign_rdreq: got we=%b re=%b state=%0d expected 0 0 0", o_we, o_re, o_state);
        end
        tick();
        i_run = 1'b0;
        checks++;
        if (o_we !== 1'b0 || o_re !== 1'b0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL ign_run: got we=%b re=%b state=%0d expected 0 0 0", o_we, o_re, o_state);
        end
`ifdef MCU_SEQ_ERRFLAG_EN
        tick();
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL ign_err: got %b expected 1", o_err); end
`endif
    endtask

    task automatic test_short_height();
        i_imgLength = 10'd2; i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (o_we !== 1'b0 || o_state !== 2'd0) begin
                errors++;
                $display("FAIL short_h k=%0d: got we=%b state=%0d expected 0 0", k, o_we, o_state);
            end
        end
        i_valid = 1'b0; i_imgLength = 10'd4;
    endtask

    task automatic test_reset_mid_conv();
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        checks++;
        if ({o_state, o_substate, o_memSelect, o_addrWr, o_addrRd, o_we, o_re,
             o_loadDone, o_convDone, o_outDone} !== 34'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got state=%0d sub=%0d sel=%0d wr=%0d rd=%0d we=%b re=%b expected all 0",
                     o_state, o_substate, o_memSelect, o_addrWr, o_addrRd, o_we, o_re);
        end
`ifdef MCU_SEQ_ERRFLAG_EN
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected 0", o_err); end
`endif
        i_reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (o_we !== 1'b0 || o_re !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet k=%0d: got we=%b re=%b expected 0 0", k, o_we, o_re);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load("pass1");
        test_conv(1'b1, 1'b0);
        test_out();
`ifdef MCU_SEQ_ERRFLAG_EN
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL clean_pass_err: got %b expected 0", o_err); end
`endif
        test_ignored();
        test_short_height();
        test_load("pass2");
        test_conv(1'b0, 1'b1);
        test_out();
`ifdef MCU_SEQ_ERRFLAG_EN
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_err); end
`endif
        test_load("pass3");
        test_reset_mid_conv();
        test_load("post_reset");
        test_conv(1'b1, 1'b0);
        test_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
